// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial subtractor built from a single full-adder slice and a carry
//   flop. Computes a - b as a + ~b + 1, LSB first, one bit per clock.
//   A start/done handshake frames each operation (WIDTH+2 cycles per op).
//
// Optional build macro:
//   SERIAL_SUB_ADD_EN - adds the 'op' input; op=1 selects a + b instead.
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   start      in   request, sampled only while idle
//   op         in   (SERIAL_SUB_ADD_EN only) 1 = add, 0 = subtract
//   a          in   [WIDTH] minuend, captured when start is accepted
//   b          in   [WIDTH] subtrahend, captured when start is accepted
//   busy       out  high while bits are being processed
//   done       out  one-cycle pulse, result outputs valid
//   diff       out  [WIDTH] result modulo 2^WIDTH
//   borrowout  out  subtract: a < b unsigned; add: unsigned carry-out
//   overflow   out  signed two's-complement overflow
//   zero       out  diff == 0
// ---------------------------------------------------------------------------
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
`ifdef SERIAL_SUB_ADD_EN
   input  logic             op,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrowout,
   output logic             overflow,
   output logic             zero
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] r_sr_q, r_sr_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic             add_q, add_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;

   logic             op_sel;
   logic             fa_sum, fa_cout;
   logic [WIDTH-1:0] r_next;

`ifdef SERIAL_SUB_ADD_EN
   assign op_sel = op;
`else
   assign op_sel = 1'b0;
`endif

   // Shared full-adder slice working on the current LSBs.
   assign fa_sum  = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
   assign fa_cout = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) |
                    (b_sr_q[0] & carry_q);
   assign r_next  = {fa_sum, r_sr_q[WIDTH-1:1]};

   always_comb begin
      state_d  = state_q;
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      r_sr_d   = r_sr_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
      add_d    = add_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      ovf_d    = ovf_q;
      zero_d   = zero_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_sr_d  = a;
               // Subtract feeds ~b with carry-in 1 (two's complement of b).
               b_sr_d  = op_sel ? b : ~b;
               carry_d = ~op_sel;
               cnt_d   = '0;
               a_msb_d = a[WIDTH-1];
               b_msb_d = b[WIDTH-1];
               add_d   = op_sel;
               state_d = RUN;
            end
         end

         RUN: begin
            carry_d = fa_cout;
            r_sr_d  = r_next;
            a_sr_d  = a_sr_q >> 1;
            b_sr_d  = b_sr_q >> 1;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d = DONE;
               // Result registers load only here, so they never expose
               // partial sums while the next operation is running.
               diff_d   = r_next;
               borrow_d = add_q ? fa_cout : ~fa_cout;
               ovf_d    = add_q ?
                  ((a_msb_q == b_msb_q) && (r_next[WIDTH-1] != a_msb_q)) :
                  ((a_msb_q != b_msb_q) && (r_next[WIDTH-1] != a_msb_q));
               zero_d   = (r_next == '0);
            end
         end

         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         r_sr_q   <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         add_q    <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         r_sr_q   <= r_sr_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         a_msb_q  <= a_msb_d;
         b_msb_q  <= b_msb_d;
         add_q    <= add_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
         zero_q   <= zero_d;
      end
   end

   assign busy      = (state_q == RUN);
   assign done      = (state_q == DONE);
   assign diff      = diff_q;
   assign borrowout = borrow_q;
   assign overflow  = ovf_q;
   assign zero      = zero_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Multi-cycle bit-serial subtractor. It is the inverse operation of the team's 1-bit full-adder cell and feeds the ALU datapath.
- Reuses one full-adder slice plus a carry flip-flop to compute A − B as A + ~B + 1, LSB first, one bit per clock.
- Start/done handshake.
- Reports difference, unsigned borrow, signed overflow and zero flag.

Parameters:
WIDTH, 8, operand/result width in bits (≥2)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  minuend; captured when start accepted
b  input  WIDTH  subtrahend; captured when start accepted
busy  output  1  high while operation in progress (RUN)
done  output  1  one-cycle pulse; results valid
diff  output  WIDTH  a − b modulo 2^WIDTH
borrowout  output  1  1 when a < b unsigned
overflow  output  1  signed two's-complement overflow
zero  output  1  1 when diff == 0

Behaviour:
- Clock and reset: one clock domain; clk, reset asynchronous active-low on reset_n.
- Reset: state=IDLE; busy, done, diff, borrowout, overflow, zero = 0; internal shift registers, counter and carry flop cleared. Reset asserted mid-operation aborts immediately; no done is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - on an edge with start=1: capture a into A_sr and ~b into B_sr; carry flop=1; bit counter=0; go to RUN.
  - start=0: remain IDLE.
- RUN:
  - each edge: sum = A_sr[0] ^ B_sr[0] ^ carry; carry = majority(A_sr[0], B_sr[0], carry); sum shifts into MSB of R_sr; A_sr and B_sr shift right; counter increments.
  - when counter == WIDTH−1 on an edge (last bit), go to DONE.
  - busy=1 throughout RUN.
- DONE (one cycle):
  - diff = R_sr.
  - borrowout = ~final carry.
  - overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the captured operand MSBs.
  - zero = (diff == 0).
  - done=1, busy=0.
  - next edge → IDLE unconditionally.
- Latency: start sampled at edge E0; bits processed at edges E1..E_WIDTH; done high for exactly the cycle after E_WIDTH. WIDTH=8 gives done 9 cycles after the start edge.
- Output registers: diff, borrowout, overflow and zero update only on entry to DONE. They hold their values through IDLE and the next RUN until the next DONE, so they never show intermediate values.
- start while busy, or during DONE: ignored, not queued. a and b may change freely after acceptance.
- Back-to-back: start may be held high; the next operation is accepted on the first IDLE edge after DONE, i.e. one op per WIDTH+2 cycles.
- Widths: all arithmetic is modulo 2^WIDTH; no sign extension. Counter width is clog2(WIDTH).

Optional Feature:
SERIAL_SUB_ADD_EN
- Defined:
  - adds input port op (1 bit), captured with a and b at start.
  - op=1 selects addition: B_sr = b (not inverted), carry initialised to 0, borrowout reports the final carry (unsigned carry-out).
  - overflow = (a[MSB] == b[MSB]) && (diff[MSB] != a[MSB]).
  - op=0 behaves exactly as subtraction.
- Undefined: no op port; subtract only, exactly as in Behaviour.

Test Plan (WIDTH=8):
1. reset_n=0 then 1; start pulse with a=0x05, b=0x03 → done high exactly 9 cycles after start edge, busy high for 8 cycles; diff=0x02, borrowout=0, overflow=0, zero=0.
2. a=0x03, b=0x05 → diff=0xFE, borrowout=1, overflow=0, zero=0.
3. a=0x80, b=0x01 → diff=0x7F, borrowout=0, overflow=1; then a=0x7F, b=0xFF → diff=0x80, borrowout=1, overflow=1.
4. a=0x5A, b=0x5A; then start held high for 30 cycles → first result diff=0x00, zero=1; subsequent dones spaced exactly 10 cycles apart; pulses while busy cause no extra done.
5. start a=0x10, b=0x01, assert reset_n=0 at 4th RUN cycle → all outputs 0 immediately, no done; after release, a=0x10, b=0x01 → diff=0x0F.
6. With SERIAL_SUB_ADD_EN, op=1: a=0xFF, b=0x01 → diff=0x00, borrowout(carry)=1, zero=1, overflow=0; a=0x7F, b=0x01 → diff=0x80, overflow=1.
